// File: rtl/clk_strobe_gen.sv
// Clock-enable generator: derives CPU F1/F2 phases, peripheral, pixel, PS/2 and IO
// strobes from one system clock, with 1x/2x/4x turbo and period-aligned pause.
module clk_strobe_gen #(
  parameter int CPU_DIV    = 28,
  parameter int F2_OFFSET  = 2,
  parameter int PER_OFFSET = 4,
  parameter int PIX_DIV    = 6,
  parameter int SLOW_DIV   = 3571
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] speed,
  input  logic       pause,
  output logic       f1_ce,
  output logic       f2_ce,
  output logic       per_ce,
  output logic       pix_ce,
  output logic       pix2x_ce,
  output logic       slow_ce,
  output logic       io_clk,
  output logic [1:0] speed_act
);

  localparam int CW = $clog2(CPU_DIV);
  localparam int PW = $clog2(PIX_DIV);
  localparam int SW = $clog2(SLOW_DIV);

  localparam logic [CW-1:0] CNT_LAST    = CW'(CPU_DIV - 1);
  localparam logic [CW-1:0] SUB_LAST_1X = CW'(CPU_DIV - 1);
  localparam logic [CW-1:0] SUB_LAST_2X = CW'(CPU_DIV / 2 - 1);
  localparam logic [CW-1:0] SUB_LAST_4X = CW'(CPU_DIV / 4 - 1);
  localparam logic [CW-1:0] F2_CNT      = CW'(F2_OFFSET);
  localparam logic [CW-1:0] PER_CNT     = CW'(PER_OFFSET);
  localparam logic [PW-1:0] PIX_LAST    = PW'(PIX_DIV - 1);
  localparam logic [PW-1:0] PIX_HALF    = PW'(PIX_DIV / 2);
  localparam logic [SW-1:0] SLOW_LAST   = SW'(SLOW_DIV - 1);

  // Strobe bank ordering: f1, f2, per, pix, pix2x, slow
  localparam int NS = 6;

  if (CPU_DIV < 8 || (CPU_DIV % 4) != 0) begin : g_bad_cpu_div
    $error("clk_strobe_gen: CPU_DIV must be a multiple of 4 and at least 8");
  end
  if (F2_OFFSET < 0 || F2_OFFSET >= CPU_DIV / 4) begin : g_bad_f2_offset
    $error("clk_strobe_gen: F2_OFFSET must lie in 0 .. CPU_DIV/4-1");
  end
  if (PER_OFFSET < 0 || PER_OFFSET >= CPU_DIV) begin : g_bad_per_offset
    $error("clk_strobe_gen: PER_OFFSET must lie in 0 .. CPU_DIV-1");
  end
  if (PIX_DIV < 2 || (PIX_DIV % 2) != 0) begin : g_bad_pix_div
    $error("clk_strobe_gen: PIX_DIV must be even and at least 2");
  end
  if (SLOW_DIV < 2) begin : g_bad_slow_div
    $error("clk_strobe_gen: SLOW_DIV must be at least 2");
  end

  logic [CW-1:0] cnt_reg, cnt_next;
  logic [CW-1:0] sub_reg, sub_next;
  logic [CW-1:0] sub_last;
  logic [1:0]    speed_act_reg, speed_act_next;
  logic [1:0]    speed_map;
  logic          pause_l_reg, pause_l_next;
  logic [PW-1:0] pc_reg, pc_next;
  logic [SW-1:0] sc_reg, sc_next;
  logic          io_clk_reg;
  logic          cnt_wrap;
  logic [NS-1:0] strobe_next;
  logic [NS-1:0] strobe_reg;

  always_comb begin
    speed_map = 2'd1;
    if (speed == 2'd0) begin
      speed_map = 2'd0;
    end else if (speed == 2'd2) begin
      speed_map = 2'd2;
    end
  end

  always_comb begin
    sub_last = SUB_LAST_2X;
    case (speed_act_reg)
      2'd0:    sub_last = SUB_LAST_1X;
      2'd2:    sub_last = SUB_LAST_4X;
      default: sub_last = SUB_LAST_2X;
    endcase
  end

  // sub_reg is cnt mod S; S always divides CPU_DIV, so it realigns cleanly at the wrap
  always_comb begin
    cnt_wrap       = (cnt_reg == CNT_LAST);
    cnt_next       = cnt_wrap ? '0 : cnt_reg + CW'(1);
    sub_next       = (cnt_wrap || sub_reg == sub_last) ? '0 : sub_reg + CW'(1);
    speed_act_next = cnt_wrap ? speed_map : speed_act_reg;
    pause_l_next   = cnt_wrap ? pause : pause_l_reg;
    pc_next        = (pc_reg == PIX_LAST) ? '0 : pc_reg + PW'(1);
    sc_next        = (sc_reg == SLOW_LAST) ? '0 : sc_reg + SW'(1);
  end

  always_comb begin
    strobe_next    = '0;
    strobe_next[0] = !pause_l_reg && (sub_reg == '0);
    strobe_next[1] = !pause_l_reg && (sub_reg == F2_CNT);
    strobe_next[2] = (cnt_reg == PER_CNT);
    strobe_next[3] = (pc_reg == '0);
    strobe_next[4] = (pc_reg == '0) || (pc_reg == PIX_HALF);
    strobe_next[5] = (sc_reg == '0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_reg       <= '0;
      sub_reg       <= '0;
      speed_act_reg <= '0;
      pause_l_reg   <= 1'b0;
      pc_reg        <= '0;
      sc_reg        <= '0;
      io_clk_reg    <= 1'b0;
    end else begin
      cnt_reg       <= cnt_next;
      sub_reg       <= sub_next;
      speed_act_reg <= speed_act_next;
      pause_l_reg   <= pause_l_next;
      pc_reg        <= pc_next;
      sc_reg        <= sc_next;
      io_clk_reg    <= ~io_clk_reg;
    end
  end

  for (genvar gi = 0; gi < NS; gi++) begin : g_strobe
    always_ff @(posedge clk) begin
      if (reset) begin
        strobe_reg[gi] <= 1'b0;
      end else begin
        strobe_reg[gi] <= strobe_next[gi];
      end
    end
  end

  assign f1_ce     = strobe_reg[0];
  assign f2_ce     = strobe_reg[1];
  assign per_ce    = strobe_reg[2];
  assign pix_ce    = strobe_reg[3];
  assign pix2x_ce  = strobe_reg[4];
  assign slow_ce   = strobe_reg[5];
  assign io_clk    = io_clk_reg;
  assign speed_act = speed_act_reg;

endmodule

// File: tb/tb_clk_strobe_gen.sv
// Bench for clk_strobe_gen: per-cycle expected outputs from a time-based model are
// queued by the driver and compared by an independent monitor.
module tb_clk_strobe_gen;

  localparam int CPU_DIV    = 28;
  localparam int F2_OFFSET  = 2;
  localparam int PER_OFFSET = 4;
  localparam int PIX_DIV    = 6;
  localparam int SLOW_DIV   = 3571;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] speed = 2'd0;
  logic       pause = 1'b0;
  logic       f1_ce, f2_ce, per_ce, pix_ce, pix2x_ce, slow_ce, io_clk;
  logic [1:0] speed_act;

  always #5 clk = ~clk;

  clk_strobe_gen #(
    .CPU_DIV   (CPU_DIV),
    .F2_OFFSET (F2_OFFSET),
    .PER_OFFSET(PER_OFFSET),
    .PIX_DIV   (PIX_DIV),
    .SLOW_DIV  (SLOW_DIV)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .speed    (speed),
    .pause    (pause),
    .f1_ce    (f1_ce),
    .f2_ce    (f2_ce),
    .per_ce   (per_ce),
    .pix_ce   (pix_ce),
    .pix2x_ce (pix2x_ce),
    .slow_ce  (slow_ce),
    .io_clk   (io_clk),
    .speed_act(speed_act)
  );

  // {f1, f2, per, pix, pix2x, slow, io_clk, speed_act[1:0]}
  typedef logic [8:0] obs_t;
  obs_t exp_q[$];

  int n_checks = 0;
  int n_fail   = 0;
  int n_model  = 0;   // clk edges since reset release
  int per_spd  = 0;   // speed applied to the current CPU period
  bit per_pse  = 1'b0;
  int mon_cyc  = 0;

  function automatic int map_speed(input logic [1:0] s);
    if (s == 2'd0) return 0;
    if (s == 2'd2) return 2;
    return 1;
  endfunction

  task automatic step(input bit rst, input logic [1:0] spd, input bit pse);
    obs_t e;
    int c;
    int s;
    @(negedge clk);
    reset = rst;
    speed = spd;
    pause = pse;
    e = '0;
    if (rst) begin
      n_model = 0;
      per_spd = 0;
      per_pse = 1'b0;
    end else begin
      c = n_model % CPU_DIV;
      s = CPU_DIV >> per_spd;
      e[8] = !per_pse && ((c % s) == 0);
      e[7] = !per_pse && ((c % s) == F2_OFFSET);
      e[6] = (c == PER_OFFSET);
      e[5] = ((n_model % PIX_DIV) == 0);
      e[4] = ((n_model % PIX_DIV) == 0) || ((n_model % PIX_DIV) == PIX_DIV / 2);
      e[3] = ((n_model % SLOW_DIV) == 0);
      e[2] = (((n_model + 1) % 2) == 1);
      if (c == CPU_DIV - 1) begin
        per_spd = map_speed(spd);
        per_pse = pse;
      end
      e[1:0] = 2'(per_spd);
      n_model++;
    end
    exp_q.push_back(e);
  endtask

  task automatic run_until(input int target, input logic [1:0] spd, input bit pse);
    while ((n_model % CPU_DIV) != target) step(1'b0, spd, pse);
  endtask

  initial begin : monitor
    obs_t e;
    obs_t act;
    forever begin
      @(posedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e   = exp_q.pop_front();
        act = {f1_ce, f2_ce, per_ce, pix_ce, pix2x_ce, slow_ce, io_clk, speed_act};
        n_checks++;
        mon_cyc++;
        if (act !== e) begin
          n_fail++;
          if (n_fail <= 10)
            $display("FAIL outputs at checked cycle %0d: got %b required %b (f1 f2 per pix pix2x slow io spd)",
                     mon_cyc, act, e);
        end
      end
    end
  end

  initial begin : watchdog
    #5_000_000;
    $display("FAIL timeout: bench did not finish, %0d checks made", n_checks);
    $fatal(1, "timeout");
  end

  initial begin : driver
    logic [1:0] rs;
    bit         rp;
    rs = 2'd0;
    rp = 1'b0;

    repeat (5) step(1'b1, 2'd0, 1'b0);
    repeat (60) step(1'b0, 2'd0, 1'b0);
    $display("phase reset_default done at model cycle %0d", n_model);

    repeat (2) step(1'b1, 2'd0, 1'b0);
    repeat (10) step(1'b0, 2'd0, 1'b0);
    repeat (90) step(1'b0, 2'd1, 1'b0);
    $display("phase speed1 done at model cycle %0d", n_model);

    repeat (56) step(1'b0, 2'd2, 1'b0);
    run_until(10, 2'd2, 1'b0);
    repeat (70) step(1'b0, 2'd3, 1'b0);
    $display("phase speed2_speed3 done at model cycle %0d", n_model);

    repeat (28) step(1'b0, 2'd0, 1'b0);
    run_until(5, 2'd0, 1'b0);
    repeat (40) step(1'b0, 2'd0, 1'b1);
    repeat (90) step(1'b0, 2'd0, 1'b0);
    $display("phase pause done at model cycle %0d", n_model);

    for (int i = 0; i < 2 * SLOW_DIV + 20; i++) begin
      if ($urandom_range(0, 49) == 0) begin
        rs = 2'($urandom_range(0, 3));
        rp = ($urandom_range(0, 3) == 0);
      end
      step(1'b0, rs, rp);
    end
    $display("phase pixel_slow done at model cycle %0d", n_model);

    run_until(0, 2'd2, 1'b0);
    run_until(1, 2'd2, 1'b0);
    repeat (3) step(1'b1, 2'd2, 1'b0);
    repeat (60) step(1'b0, 2'd0, 1'b0);
    $display("phase reset_midperiod done at model cycle %0d", n_model);

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 99) == 0) begin
        repeat ($urandom_range(1, 3)) step(1'b1, rs, rp);
      end else begin
        if ($urandom_range(0, 19) == 0) begin
          rs = 2'($urandom_range(0, 3));
          rp = ($urandom_range(0, 4) == 0);
        end
        step(1'b0, rs, rp);
      end
    end
    $display("phase random done at model cycle %0d", n_model);

    @(posedge clk);
    #4;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
